rs_pulse_driver: RTL and testbench

//  Command-side driver for an RS flip-flop. Accepts SET/RESET/TOGGLE/NOP

---
 rtl/rs_pulse_driver.sv | 128 ++++++++++++
 tb/tb_rs_pulse_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_pulse_driver.sv
// Command-side driver for an RS flip-flop: turns SET/RESET/TOGGLE/NOP commands
// into registered, mutually exclusive s/r pulses and tracks the expected q.
//
// state | meaning
// IDLE  | ready for a command
// PULSE | s or r driven high for PULSE_W cycles
// GAP   | both low for GAP_W cycles after the pulse
// DONE  | one-cycle completion strobe
module rs_pulse_driver #(
  parameter int PULSE_W        = 2,
  parameter int GAP_W          = 1,
  parameter int CNT_W          = 4,
  parameter int INIT_Q         = 0,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  output logic       q_shadow,
  output logic       busy,
  output logic       done
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("rs_pulse_driver: CNT_W out of range");
  end
  if (PULSE_W < 1 || longint'(PULSE_W) > CNT_MAX) begin : g_bad_pulse_w
    $error("rs_pulse_driver: PULSE_W out of range");
  end
  if (GAP_W < 0 || longint'(GAP_W) > CNT_MAX) begin : g_bad_gap_w
    $error("rs_pulse_driver: GAP_W out of range");
  end
  if (INIT_Q < 0 || INIT_Q > 1) begin : g_bad_init_q
    $error("rs_pulse_driver: INIT_Q must be 0 or 1");
  end
  if (SKIP_REDUNDANT < 0 || SKIP_REDUNDANT > 1) begin : g_bad_skip
    $error("rs_pulse_driver: SKIP_REDUNDANT must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               tgt, tgt_next;
  logic               q_next;
  logic               op_tgt;
  logic               accept;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_comb begin
    case (cmd_op)
      OP_SET:   op_tgt = 1'b1;
      OP_RESET: op_tgt = 1'b0;
      default:  op_tgt = ~q_shadow;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tgt_next   = tgt;
    q_next     = q_shadow;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_next = op_tgt;
          if (cmd_op == OP_NOP || (SKIP_REDUNDANT != 0 && op_tgt == q_shadow)) begin
            state_next = DONE;
          end else begin
            state_next = PULSE;
            cnt_next   = CNT_W'(PULSE_W);
          end
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(1)) begin
          q_next     = tgt;
          cnt_next   = CNT_W'(GAP_W);
          state_next = (GAP_W == 0) ? DONE : GAP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // s/r and ready come from next-state so they line up exactly with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tgt       <= 1'b0;
      q_shadow  <= (INIT_Q != 0);
      s         <= 1'b0;
      r         <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      tgt       <= tgt_next;
      q_shadow  <= q_next;
      s         <= (state_next == PULSE) && tgt_next;
      r         <= (state_next == PULSE) && !tgt_next;
      cmd_ready <= (state_next == IDLE);
    end
  end

  a_sr_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(s && r));

endmodule

// File: tb/tb_rs_pulse_driver.sv
// Self-checking bench for rs_pulse_driver: scoreboard-driven command table,
// random back-to-back stream, reset abort and alternate-parameter instances.
module tb_rs_pulse_driver;

  typedef struct {
    int ps;
    int pr;
    int lat;
    int q;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready, s, r, q_shadow, busy, done;

  logic [1:0] vx;
  logic [3:0] opx;
  logic [1:0] sx, rx, qx, rdyx, busyx, donex;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];
  int   mon_active = 0;
  int   mon_lat, mon_ps, mon_pr;

  rs_pulse_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .s(s), .r(r), .q_shadow(q_shadow), .busy(busy), .done(done)
  );

  rs_pulse_driver #(.SKIP_REDUNDANT(0)) dut_noskip (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vx[0]), .cmd_op(opx[1:0]),
    .cmd_ready(rdyx[0]), .s(sx[0]), .r(rx[0]), .q_shadow(qx[0]), .busy(busyx[0]), .done(donex[0])
  );

  rs_pulse_driver #(.GAP_W(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vx[1]), .cmd_op(opx[3:2]),
    .cmd_ready(rdyx[1]), .s(sx[1]), .r(rx[1]), .q_shadow(qx[1]), .busy(busyx[1]), .done(donex[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference behaviour for the default instance (PULSE_W=2, GAP_W=1, skip on)
  function automatic exp_t exp_for(input logic [1:0] op, input int q);
    exp_t e;
    int   t;
    e = '{0, 0, 1, q};
    if (op == 2'b00) return e;
    t = (op == 2'b01) ? 1 : (op == 2'b10) ? 0 : 1 - q;
    if (t == q) return e;
    e.ps  = t ? 2 : 0;
    e.pr  = t ? 0 : 2;
    e.lat = 4;
    e.q   = t;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
    end else begin
      chk("sr_exclusive", int'(s && r), 0);
      if (mon_active != 0) begin
        exp_t e;
        mon_lat++;
        if (s) mon_ps++;
        if (r) mon_pr++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", mon_lat, e.lat);
            chk("s_cycles", mon_ps, e.ps);
            chk("r_cycles", mon_pr, e.pr);
            chk("q_shadow_at_done", int'(q_shadow), e.q);
          end
          mon_active = 0;
        end
      end else begin
        chk("spurious_done", int'(done), 0);
        if (cmd_valid && cmd_ready) begin
          mon_active = 1;
          mon_lat = 0;
          mon_ps = 0;
          mon_pr = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic send(input logic [1:0] op, input exp_t e);
    wait_ready();
    cmd_op = op;
    cmd_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic run_x(input int k, input logic [1:0] op, input int eps, input int epr,
                       input int elat, input int eq, input string tag);
    int ps = 0;
    int pr = 0;
    int lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (rdyx[k]) break;
      @(posedge clk); #1;
    end
    chk({tag, "_ready"}, int'(rdyx[k]), 1);
    vx[k] = 1'b1;
    opx[2*k +: 2] = op;
    @(posedge clk); #1;
    vx[k] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sx[k] && rx[k]) chk({tag, "_sr_exclusive"}, 1, 0);
      if (sx[k]) ps++;
      if (rx[k]) pr++;
      if (donex[k]) break;
      lat++;
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, int'(donex[k]), 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_s_cycles"}, ps, eps);
    chk({tag, "_r_cycles"}, pr, epr);
    chk({tag, "_q_shadow"}, int'(qx[k]), eq);
  endtask

  vec_t vecs[10];

  initial begin
    int   mq;
    int   n_acc;
    exp_t e;

    vecs[0] = '{2'b01, '{0, 0, 1, 1}};
    vecs[1] = '{2'b11, '{0, 2, 4, 0}};
    vecs[2] = '{2'b00, '{0, 0, 1, 0}};
    vecs[3] = '{2'b10, '{0, 0, 1, 0}};
    vecs[4] = '{2'b11, '{2, 0, 4, 1}};
    vecs[5] = '{2'b11, '{0, 2, 4, 0}};
    vecs[6] = '{2'b01, '{2, 0, 4, 1}};
    vecs[7] = '{2'b11, '{0, 2, 4, 0}};
    vecs[8] = '{2'b10, '{0, 0, 1, 0}};
    vecs[9] = '{2'b01, '{2, 0, 4, 1}};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    vx = '0;
    opx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q_shadow", int'(q_shadow), 0);
    chk("rst_q_noskip", int'(qx[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", int'(cmd_ready), 1);

    // Reset while the SET pulse is in its first cycle
    cmd_op = 2'b01;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_s_before", int'(s), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s_async", int'(s), 0);
    chk("abort_r_async", int'(r), 0);
    chk("abort_busy_async", int'(busy), 0);
    chk("abort_done_async", int'(done), 0);
    chk("abort_q_async", int'(q_shadow), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after", int'(cmd_ready), 1);
    chk("abort_no_done", int'(done), 0);
    send(2'b10, '{0, 0, 1, 0});

    // SET with full cycle-by-cycle timing
    wait_ready();
    sb.push_back('{2, 0, 4, 1});
    cmd_op = 2'b01;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("set_c1_s", int'(s), 1);
    chk("set_c1_r", int'(r), 0);
    chk("set_c1_ready", int'(cmd_ready), 0);
    chk("set_c1_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("set_c2_s", int'(s), 1);
    chk("set_c2_q", int'(q_shadow), 0);
    @(posedge clk); #1;
    chk("set_c3_s", int'(s), 0);
    chk("set_c3_q", int'(q_shadow), 1);
    chk("set_c3_done", int'(done), 0);
    @(posedge clk); #1;
    chk("set_c4_done", int'(done), 1);
    chk("set_c4_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("set_c5_ready", int'(cmd_ready), 1);
    chk("set_c5_done", int'(done), 0);
    chk("set_c5_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) send(vecs[i].op, vecs[i].e);

    // Valid held high, op changing every cycle: only ops offered while ready count
    mq = 1;
    n_acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cmd_op = 2'($urandom_range(0, 3));
      if (cmd_ready) begin
        e = exp_for(cmd_op, mq);
        mq = e.q;
        sb.push_back(e);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && mon_active == 0) break;
      @(posedge clk); #1;
    end
    chk("stream_drained", sb.size(), 0);
    chk("stream_accepts", int'(n_acc >= 5), 1);
    chk("stream_final_q", int'(q_shadow), mq);

    // No redundant skipping: SET on q=1 still pulses
    run_x(0, 2'b01, 2, 0, 4, 1, "noskip_set1");
    run_x(0, 2'b01, 2, 0, 4, 1, "noskip_set2");
    run_x(0, 2'b00, 0, 0, 1, 1, "noskip_nop");
    run_x(0, 2'b10, 0, 2, 4, 0, "noskip_reset");

    // Zero guard gap: done right after the pulse
    run_x(1, 2'b01, 2, 0, 3, 1, "nogap_set");
    run_x(1, 2'b11, 0, 2, 3, 0, "nogap_toggle");
    run_x(1, 2'b00, 0, 0, 1, 0, "nogap_nop");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
